// File: rtl/game_datapath.sv
// rtl/game_datapath.sv - memory-game datapath: LFSR pattern source, reveal timer, compare, BCD score, mistakes
//
// Purpose: generates a pseudo-random 8-bit target pattern, times its reveal
// window, compares the player's switches against it, and keeps a saturating
// two-digit BCD score and a saturating 2-bit mistake count for the controller.
//
// Ports:
//   i_clk            system clock, all state on rising edge
//   i_reset          synchronous active-high reset
//   i_new_game       clear score and mistakes
//   i_sequence_ld    capture current LFSR value as target, (re)start reveal
//   i_score_ld       score + 1 (BCD, saturates at 99)
//   i_mistakes_ld    mistakes + 1 (saturates at 3)
//   i_switches[7:0]  player's attempted pattern
//   o_sequence[7:0]  registered target pattern
//   o_show_seq       high while the target is being revealed
//   o_sequence_check registered (switches == sequence)
//   o_mistakes[1:0]  saturating mistake count
//   o_score[7:0]     BCD score {tens, ones}

module game_datapath #(
    parameter logic [7:0]  SEED          = 8'hA5,
    parameter logic [31:0] REVEAL_CYCLES = 32'd50_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_new_game,
    input  logic       i_sequence_ld,
    input  logic       i_score_ld,
    input  logic       i_mistakes_ld,
    input  logic [7:0] i_switches,
    output logic [7:0] o_sequence,
    output logic       o_show_seq,
    output logic       o_sequence_check,
    output logic [1:0] o_mistakes,
    output logic [7:0] o_score
);

    logic [7:0]  r_lfsr;
    logic [7:0]  r_sequence;
    logic [31:0] r_reveal_cnt;
    logic        r_show_seq;
    logic        r_sequence_check;
    logic [3:0]  r_score_tens;
    logic [3:0]  r_score_ones;
    logic [1:0]  r_mistakes;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3.
    logic w_lfsr_fb;
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    logic w_score_max;
    assign w_score_max = (r_score_tens == 4'd9) && (r_score_ones == 4'd9);

    // LFSR, target pattern and reveal window
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr           <= SEED;
            r_sequence       <= 8'h00;
            r_reveal_cnt     <= 32'd0;
            r_show_seq       <= 1'b0;
            r_sequence_check <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            // Compare against the pre-edge target even when a new one loads now.
            r_sequence_check <= (i_switches == r_sequence);
            if (i_sequence_ld) begin
                r_sequence   <= r_lfsr;
                r_reveal_cnt <= REVEAL_CYCLES - 32'd1;
                r_show_seq   <= 1'b1;
            end else if (r_reveal_cnt != 32'd0) begin
                // Counter reaching zero still leaves one last visible cycle.
                r_reveal_cnt <= r_reveal_cnt - 32'd1;
            end else begin
                r_show_seq <= 1'b0;
            end
        end
    end

    // Score and mistakes
    always_ff @(posedge i_clk) begin
        if (i_reset || i_new_game) begin
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_mistakes   <= 2'd0;
        end else begin
            if (i_score_ld && !w_score_max) begin
                if (r_score_ones == 4'd9) begin
                    r_score_ones <= 4'd0;
                    r_score_tens <= r_score_tens + 4'd1;
                end else begin
                    r_score_ones <= r_score_ones + 4'd1;
                end
            end
            if (i_mistakes_ld && (r_mistakes != 2'd3)) begin
                r_mistakes <= r_mistakes + 2'd1;
            end
        end
    end

    assign o_sequence       = r_sequence;
    assign o_show_seq       = r_show_seq;
    assign o_sequence_check = r_sequence_check;
    assign o_mistakes       = r_mistakes;
    assign o_score          = {r_score_tens, r_score_ones};

endmodule

// File: tb/tb_game_datapath.sv
// tb/tb_game_datapath.sv - self-checking bench for game_datapath

module tb_game_datapath;

    localparam int         RC   = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       reset, new_game, sequence_ld, score_ld, mistakes_ld;
    logic [7:0] switches;
    logic [7:0] o_sequence, o_score;
    logic       o_show_seq, o_sequence_check;
    logic [1:0] o_mistakes;

    always #5 clk = ~clk;

    game_datapath #(.SEED(SEED), .REVEAL_CYCLES(RC)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_new_game       (new_game),
        .i_sequence_ld    (sequence_ld),
        .i_score_ld       (score_ld),
        .i_mistakes_ld    (mistakes_ld),
        .i_switches       (switches),
        .o_sequence       (o_sequence),
        .o_show_seq       (o_show_seq),
        .o_sequence_check (o_sequence_check),
        .o_mistakes       (o_mistakes),
        .o_score          (o_score)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: score as a plain integer, reveal as "cycles left".
    logic [7:0] m_lfsr, m_seq;
    int         m_rem, m_score, m_mis;
    logic       m_chk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_lfsr = SEED; m_seq = 8'h00; m_rem = 0; m_chk = 1'b0;
            m_score = 0; m_mis = 0;
        end else begin
            m_chk = (switches == m_seq);
            if (sequence_ld) begin
                m_seq = m_lfsr;
                m_rem = RC;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            m_lfsr = lfsr_next(m_lfsr);
            if (new_game) begin
                m_score = 0; m_mis = 0;
            end else begin
                if (score_ld && m_score < 99) m_score++;
                if (mistakes_ld && m_mis < 3) m_mis++;
            end
        end
        #1;
        chk("m_sequence", o_sequence, m_seq);
        chk("m_show_seq", o_show_seq, m_rem > 0);
        chk("m_check", o_sequence_check, m_chk);
        chk("m_score", o_score, to_bcd(m_score));
        chk("m_mistakes", o_mistakes, m_mis);
    endtask

    task automatic idle();
        reset = 0; new_game = 0; sequence_ld = 0; score_ld = 0; mistakes_ld = 0;
    endtask

    initial begin
        bit   seen [256];
        int   distinct, highs;
        logic [7:0] sv;

        idle();
        switches = 8'h00;
        reset = 1;
        tick(); tick();
        chk("rst_seq", o_sequence, 8'h00);
        chk("rst_show", o_show_seq, 1'b0);
        chk("rst_check", o_sequence_check, 1'b0);
        chk("rst_score", o_score, 8'h00);
        chk("rst_mis", o_mistakes, 2'h0);

        // LFSR sweep: load every cycle, first three values pinned by hand.
        idle();
        sequence_ld = 1;
        tick(); chk("lfsr_0", o_sequence, 8'hA5);
        tick(); chk("lfsr_1", o_sequence, 8'h4A);
        tick(); chk("lfsr_2", o_sequence, 8'h95);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[8'hA5] = 1; seen[8'h4A] = 1; seen[8'h95] = 1;
        for (int i = 3; i < 255; i++) begin
            tick();
            sv = o_sequence;
            seen[sv] = 1'b1;
        end
        distinct = 0;
        foreach (seen[i]) if (seen[i]) distinct++;
        chk("lfsr_distinct", distinct, 255);
        chk("lfsr_no_zero", seen[0], 1'b0);
        tick(); chk("lfsr_period", o_sequence, 8'hA5);
        sequence_ld = 0;
        for (int i = 0; i < RC + 1; i++) tick();
        chk("show_idle", o_show_seq, 1'b0);

        // Reveal window: exactly RC cycles high, then restart mid-window.
        highs = 0;
        sequence_ld = 1; tick(); sequence_ld = 0;
        if (o_show_seq) highs++;
        for (int i = 0; i < 8; i++) begin tick(); if (o_show_seq) highs++; end
        chk("reveal_len", highs, RC);
        sequence_ld = 1; tick(); sequence_ld = 0;
        tick();
        sequence_ld = 1; tick(); sequence_ld = 0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (o_show_seq) highs++; end
        chk("reveal_restart", highs, RC - 1);

        // Compare latency.
        switches = m_seq;
        tick(); chk("cmp_equal", o_sequence_check, 1'b1);
        switches = m_seq ^ 8'h01;
        tick(); chk("cmp_differ", o_sequence_check, 1'b0);

        // Score stepping and saturation.
        new_game = 1; tick(); new_game = 0;
        score_ld = 1;
        for (int i = 0; i < 9; i++) tick();
        chk("score_09", o_score, 8'h09);
        tick(); chk("score_10", o_score, 8'h10);
        for (int i = 0; i < 89; i++) tick();
        chk("score_99", o_score, 8'h99);
        tick(); chk("score_sat", o_score, 8'h99);
        score_ld = 0;

        // Mistakes saturation and interaction with score / new_game.
        new_game = 1; tick(); new_game = 0;
        mistakes_ld = 1;
        tick(); chk("mis_1", o_mistakes, 2'h1);
        tick(); chk("mis_2", o_mistakes, 2'h2);
        tick(); chk("mis_3", o_mistakes, 2'h3);
        tick(); chk("mis_sat", o_mistakes, 2'h3);
        new_game = 1; mistakes_ld = 0; tick(); new_game = 0;
        score_ld = 1; mistakes_ld = 1; tick();
        chk("both_score", o_score, 8'h01);
        chk("both_mis", o_mistakes, 2'h1);
        new_game = 1; tick(); idle();
        chk("ng_score", o_score, 8'h00);
        chk("ng_mis", o_mistakes, 2'h0);

        // Reset mid-reveal with score 42.
        score_ld = 1;
        for (int i = 0; i < 42; i++) tick();
        score_ld = 0;
        chk("pre_rst_score", o_score, 8'h42);
        sequence_ld = 1; tick(); sequence_ld = 0; tick();
        chk("pre_rst_show", o_show_seq, 1'b1);
        reset = 1; sequence_ld = 1; score_ld = 1; mistakes_ld = 1; switches = m_seq;
        tick(); idle();
        chk("mid_rst_seq", o_sequence, 8'h00);
        chk("mid_rst_show", o_show_seq, 1'b0);
        chk("mid_rst_check", o_sequence_check, 1'b0);
        chk("mid_rst_score", o_score, 8'h00);
        chk("mid_rst_mis", o_mistakes, 2'h0);
        sequence_ld = 1; tick(); sequence_ld = 0;
        chk("post_rst_lfsr", o_sequence, 8'hA5);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(199) == 0);
            new_game    = ($urandom_range(29) == 0);
            sequence_ld = ($urandom_range(7) == 0);
            score_ld    = ($urandom_range(2) == 0);
            mistakes_ld = ($urandom_range(5) == 0);
            switches    = $urandom_range(1) ? m_seq : 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
